// File: rtl/spi_flash_reader_if.sv
// Request and read-stream bundle for spi_flash_reader.
// The master side issues read requests and consumes bytes; the slave side is the reader.
interface spi_flash_reader_if #(
   parameter int unsigned LEN_W = 8
);
   logic             start;
   logic [23:0]      addr;
   logic [LEN_W-1:0] len;
   logic             busy;
   logic             done;
   logic [7:0]       rd_data;
   logic             rd_valid;
   logic             rd_ready;

   modport master (
      output start, addr, len, rd_ready,
      input  busy, done, rd_data, rd_valid
   );

   modport slave (
      input  start, addr, len, rd_ready,
      output busy, done, rd_data, rd_valid
   );
endinterface

// File: rtl/spi_flash_reader.sv
// SPI NOR flash reader: sends READ (0x03) plus a 24-bit address in mode 0, then streams
// len bytes out over a valid/ready port. SPI clock is stretched (held low) while a
// received byte waits for the consumer, so no data is lost under backpressure.
module spi_flash_reader #(
   parameter int unsigned CLK_DIV = 2,
   parameter int unsigned LEN_W   = 8
) (
   input  logic                clock,
   input  logic                resetb,
   spi_flash_reader_if.slave   bus,
   output logic                flash_csb,
   output logic                flash_clk,
   output logic                flash_io0,
   input  logic                flash_io1
);

   // Counter is shared by the half-bit timer and the 2*CLK_DIV chip-select gap.
   localparam int unsigned     CntW     = $clog2(2 * CLK_DIV) + 1;
   localparam logic [CntW-1:0] HalfLast = CntW'(CLK_DIV - 1);
   localparam logic [CntW-1:0] GapLast  = CntW'(2 * CLK_DIV - 1);
   localparam logic [7:0]      CmdRead  = 8'h03;

   typedef enum logic [2:0] {
      StIdle,
      StShiftOut,
      StShiftIn,
      StHold,
      StGap
   } state_t;

   state_t           state;
   logic [CntW-1:0]  cnt;
   logic [4:0]       bit_cnt;
   logic [31:0]      tx_shift;
   logic [7:0]       rx_shift;
   logic [LEN_W-1:0] remaining;

   // Single FSM; every output is a register so the SPI pins are glitch-free.
   always_ff @(posedge clock) begin
      if (!resetb) begin
         state        <= StIdle;
         cnt          <= '0;
         bit_cnt      <= '0;
         tx_shift     <= '0;
         rx_shift     <= '0;
         remaining    <= '0;
         flash_csb    <= 1'b1;
         flash_clk    <= 1'b0;
         flash_io0    <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.rd_valid <= 1'b0;
         bus.rd_data  <= '0;
      end else begin
         bus.done <= 1'b0;
         unique case (state)
            StIdle: begin
               if (bus.start && (bus.len != '0)) begin
                  tx_shift  <= {CmdRead, bus.addr};
                  remaining <= bus.len;
                  flash_csb <= 1'b0;
                  flash_clk <= 1'b0;
                  flash_io0 <= CmdRead[7];
                  cnt       <= '0;
                  bit_cnt   <= '0;
                  bus.busy  <= 1'b1;
                  state     <= StShiftOut;
               end
            end

            StShiftOut: begin
               cnt <= cnt + 1'b1;
               if (!flash_clk) begin
                  if (cnt == HalfLast) begin
                     flash_clk <= 1'b1;
                     cnt       <= '0;
                  end
               end else if (cnt == HalfLast) begin
                  flash_clk <= 1'b0;
                  cnt       <= '0;
                  if (bit_cnt == 5'd31) begin
                     flash_io0 <= 1'b0;
                     bit_cnt   <= '0;
                     state     <= StShiftIn;
                  end else begin
                     // MOSI changes only at the start of a low phase.
                     flash_io0 <= tx_shift[30];
                     tx_shift  <= tx_shift << 1;
                     bit_cnt   <= bit_cnt + 1'b1;
                  end
               end
            end

            StShiftIn: begin
               cnt <= cnt + 1'b1;
               if (!flash_clk) begin
                  if (cnt == HalfLast) begin
                     // Sample MISO on the edge that raises SCK.
                     flash_clk <= 1'b1;
                     cnt       <= '0;
                     rx_shift  <= {rx_shift[6:0], flash_io1};
                  end
               end else if (cnt == HalfLast) begin
                  flash_clk <= 1'b0;
                  cnt       <= '0;
                  if (bit_cnt == 5'd7) begin
                     bus.rd_data  <= rx_shift;
                     bus.rd_valid <= 1'b1;
                     bit_cnt      <= '0;
                     state        <= StHold;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end

            StHold: begin
               // SCK stays low here; csb low keeps the flash mid-command.
               if (bus.rd_ready) begin
                  bus.rd_valid <= 1'b0;
                  remaining    <= remaining - 1'b1;
                  cnt          <= '0;
                  if (remaining != LEN_W'(1)) begin
                     state <= StShiftIn;
                  end else begin
                     flash_csb <= 1'b1;
                     state     <= StGap;
                  end
               end
            end

            StGap: begin
               cnt <= cnt + 1'b1;
               if (cnt == GapLast) begin
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  cnt      <= '0;
                  state    <= StIdle;
               end
            end

            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader: two instances (CLK_DIV=2 and CLK_DIV=1), each
// talking to a small mode-0 flash model with fixed contents.
module tb_spi_flash_reader;

   logic clock = 1'b0;
   logic resetb;
   always #5 clock = ~clock;

   spi_flash_reader_if #(.LEN_W(8)) bus_a ();
   spi_flash_reader_if #(.LEN_W(8)) bus_b ();

   logic csb_a, sck_a, mosi_a;
   logic csb_b, sck_b, mosi_b;
   logic miso [2] = '{1'b0, 1'b0};

   spi_flash_reader #(.CLK_DIV(2), .LEN_W(8)) dut_a (
      .clock     (clock),
      .resetb    (resetb),
      .bus       (bus_a),
      .flash_csb (csb_a),
      .flash_clk (sck_a),
      .flash_io0 (mosi_a),
      .flash_io1 (miso[0])
   );

   spi_flash_reader #(.CLK_DIV(1), .LEN_W(8)) dut_b (
      .clock     (clock),
      .resetb    (resetb),
      .bus       (bus_b),
      .flash_csb (csb_b),
      .flash_clk (sck_b),
      .flash_io0 (mosi_b),
      .flash_io1 (miso[1])
   );

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Flash contents used by the bench.
   function automatic logic [7:0] flash_byte(input logic [23:0] a);
      case (a)
         24'h000100: return 8'hA5;
         24'h000101: return 8'h3C;
         24'h000102: return 8'hFF;
         24'h000103: return 8'h00;
         24'hFFFFFF: return 8'h5A;
         default:    return a[7:0] ^ 8'h6C;
      endcase
   endfunction

   // Mode-0 responder state, one slot per DUT.
   logic [31:0] m_cmd      [2] = '{32'h0, 32'h0};
   int          m_bits     [2] = '{0, 0};
   int          m_nb       [2] = '{0, 0};
   logic        m_sck_prev [2] = '{1'b0, 1'b0};

   task automatic flash_step(input int k, input logic csb, input logic sck, input logic mosi);
      logic [7:0] cur;
      if (csb) begin
         m_bits[k] = 0;
         m_nb[k]   = 0;
      end else begin
         if (sck && !m_sck_prev[k] && m_bits[k] < 32) begin
            m_cmd[k]  = {m_cmd[k][30:0], mosi};
            m_bits[k] = m_bits[k] + 1;
         end
         if (!sck && m_sck_prev[k] && m_bits[k] == 32) begin
            cur     = flash_byte(m_cmd[k][23:0] + 24'(m_nb[k] / 8));
            miso[k] = cur[7 - (m_nb[k] % 8)];
            m_nb[k] = m_nb[k] + 1;
         end
      end
      m_sck_prev[k] = sck;
   endtask

   // Consumer / monitor state.
   int         ready_mode = 0;
   logic [7:0] bytes_a [$];
   int         valid_cyc [$];
   logic       valid_prev_a = 1'b0;
   int         hold_bad = 0;
   int         done_a = 0;
   int         done_cyc_a = 0;
   int         last_hs_a = 0;
   logic [7:0] byte_b = 8'h00;
   int         nbytes_b = 0;
   int         done_b = 0;
   int         rises_b = 0;
   int         bad_period_b = 0;
   int         last_rise_b = -1;
   logic       sck_prev_b = 1'b0;

   // Flash models, consumers and monitors, all evaluated on the falling clock edge.
   always @(negedge clock) begin
      flash_step(0, csb_a, sck_a, mosi_a);
      flash_step(1, csb_b, sck_b, mosi_b);

      bus_a.rd_ready = (ready_mode == 0) || (cyc % 3 == 0);
      if (bus_a.rd_valid && !valid_prev_a) valid_cyc.push_back(cyc);
      valid_prev_a = bus_a.rd_valid;
      if (bus_a.rd_valid && sck_a) hold_bad++;
      if (bus_a.rd_valid && bus_a.rd_ready) begin
         bytes_a.push_back(bus_a.rd_data);
         last_hs_a = cyc;
      end
      if (bus_a.done) begin
         done_a++;
         done_cyc_a = cyc;
      end

      bus_b.rd_ready = 1'b1;
      if (bus_b.rd_valid) begin
         byte_b = bus_b.rd_data;
         nbytes_b++;
      end
      if (bus_b.done) done_b++;
      if (csb_b) begin
         last_rise_b = -1;
      end else if (sck_b && !sck_prev_b) begin
         rises_b++;
         if (last_rise_b >= 0 && cyc - last_rise_b != 2) bad_period_b++;
         last_rise_b = cyc;
      end
      sck_prev_b = sck_b;
   end

   function automatic int byte_at(input int i);
      return (i < bytes_a.size()) ? int'(bytes_a[i]) : 32'hEE;
   endfunction

   function automatic int valid_at(input int i);
      return (i < valid_cyc.size()) ? valid_cyc[i] : -100000;
   endfunction

   // Called half a cycle after a falling edge; start is high for exactly the cycle t0.
   task automatic start_read(input logic [23:0] a, input logic [7:0] n, output int t0);
      bus_a.start = 1'b1;
      bus_a.addr  = a;
      bus_a.len   = n;
      t0          = cyc;
      @(negedge clock);
      #1;
      bus_a.start = 1'b0;
   endtask

   task automatic wait_done_a(input int budget, input string tag);
      int base;
      int i;
      base = done_a;
      i    = 0;
      while (done_a == base && i < budget) begin
         @(negedge clock);
         #1;
         i++;
      end
      check(tag, 32'(done_a != base), 1);
   endtask

   initial begin
      int t0;
      int t1;
      int qb;
      int vb;
      int hb;
      int db;
      int k;
      int bad;
      logic [7:0] exp4 [4];
      exp4 = '{8'hA5, 8'h3C, 8'hFF, 8'h00};

      resetb      = 1'b0;
      bus_a.start = 1'b0;
      bus_a.addr  = '0;
      bus_a.len   = '0;
      bus_b.start = 1'b0;
      bus_b.addr  = '0;
      bus_b.len   = '0;
      repeat (3) @(negedge clock);
      #1;

      // Reset values.
      check("rst_csb", 32'(csb_a), 1);
      check("rst_clk", 32'(sck_a), 0);
      check("rst_io0", 32'(mosi_a), 0);
      check("rst_busy", 32'(bus_a.busy), 0);
      check("rst_done", 32'(bus_a.done), 0);
      check("rst_valid", 32'(bus_a.rd_valid), 0);
      check("rst_data", 32'(bus_a.rd_data), 0);
      resetb = 1'b1;
      repeat (2) @(negedge clock);
      #1;

      // len = 0 is ignored.
      db = done_a;
      start_read(24'h000100, 8'd0, t0);
      bad = 0;
      repeat (12) begin
         if (!csb_a || bus_a.busy) bad++;
         @(negedge clock);
         #1;
      end
      check("len0_idle", bad, 0);
      check("len0_no_done", done_a - db, 0);

      // Four-byte read, consumer always ready.
      qb = bytes_a.size();
      vb = valid_cyc.size();
      hb = hold_bad;
      db = done_a;
      start_read(24'h000100, 8'd4, t0);
      check("rd1_csb_low", 32'(csb_a), 0);
      check("rd1_io0_bit31", 32'(mosi_a), 0);
      check("rd1_busy", 32'(bus_a.busy), 1);
      wait_done_a(3000, "rd1_done");
      check("rd1_csb_at_done", 32'(csb_a), 1);
      check("rd1_busy_at_done", 32'(bus_a.busy), 0);
      check("rd1_cmd", m_cmd[0], 32'h03000100);
      for (int i = 0; i < 4; i++) check($sformatf("rd1_byte%0d", i), byte_at(qb + i), 32'(exp4[i]));
      check("rd1_first_valid", valid_at(vb) - t0, 161);
      check("rd1_byte_period", valid_at(vb + 1) - valid_at(vb), 33);
      check("rd1_done_latency", done_cyc_a - last_hs_a, 5);
      repeat (20) @(negedge clock);
      #1;
      check("rd1_count", bytes_a.size() - qb, 4);
      check("rd1_done_once", done_a - db, 1);
      check("rd1_hold_clk_low", hold_bad - hb, 0);

      // Same read with rd_ready high one cycle in three.
      ready_mode = 1;
      qb = bytes_a.size();
      hb = hold_bad;
      start_read(24'h000100, 8'd4, t0);
      wait_done_a(4000, "rd2_done");
      repeat (10) @(negedge clock);
      #1;
      check("rd2_count", bytes_a.size() - qb, 4);
      for (int i = 0; i < 4; i++) check($sformatf("rd2_byte%0d", i), byte_at(qb + i), 32'(exp4[i]));
      check("rd2_hold_clk_low", hold_bad - hb, 0);
      ready_mode = 0;

      // Start during busy is dropped; start on the done cycle is taken.
      qb = bytes_a.size();
      db = done_a;
      start_read(24'h000100, 8'd1, t0);
      repeat (20) @(negedge clock);
      #1;
      start_read(24'h000102, 8'd3, t1);
      wait_done_a(2000, "b2b_done1");
      start_read(24'h000101, 8'd1, t0);
      check("b2b_csb_next", 32'(csb_a), 0);
      check("b2b_busy_next", 32'(bus_a.busy), 1);
      wait_done_a(2000, "b2b_done2");
      repeat (40) @(negedge clock);
      #1;
      check("b2b_count", bytes_a.size() - qb, 2);
      check("b2b_byte0", byte_at(qb), 32'hA5);
      check("b2b_byte1", byte_at(qb + 1), 32'h3C);
      check("b2b_cmd", m_cmd[0], 32'h03000101);
      check("b2b_done_count", done_a - db, 2);
      check("b2b_idle_csb", 32'(csb_a), 1);

      // Reset in the middle of byte 2.
      qb = bytes_a.size();
      start_read(24'h000100, 8'd4, t0);
      k = 0;
      while (bytes_a.size() - qb < 1 && k < 1000) begin
         @(negedge clock);
         #1;
         k++;
      end
      check("mid_rst_byte1", bytes_a.size() - qb, 1);
      repeat (8) @(negedge clock);
      #1;
      db = done_a;
      resetb = 1'b0;
      @(negedge clock);
      #1;
      check("mid_rst_csb", 32'(csb_a), 1);
      check("mid_rst_clk", 32'(sck_a), 0);
      check("mid_rst_busy", 32'(bus_a.busy), 0);
      check("mid_rst_valid", 32'(bus_a.rd_valid), 0);
      resetb = 1'b1;
      repeat (10) @(negedge clock);
      #1;
      check("mid_rst_no_done", done_a - db, 0);
      qb = bytes_a.size();
      start_read(24'h000100, 8'd1, t0);
      wait_done_a(2000, "after_rst_done");
      check("after_rst_byte", byte_at(qb), 32'hA5);

      // CLK_DIV = 1 instance, top of the address space.
      bus_b.start = 1'b1;
      bus_b.addr  = 24'hFFFFFF;
      bus_b.len   = 8'd1;
      @(negedge clock);
      #1;
      bus_b.start = 1'b0;
      check("div1_csb_low", 32'(csb_b), 0);
      k = 0;
      while (done_b == 0 && k < 1000) begin
         @(negedge clock);
         #1;
         k++;
      end
      check("div1_done", done_b, 1);
      check("div1_cmd", m_cmd[1], 32'h03FFFFFF);
      check("div1_byte", 32'(byte_b), 32'h5A);
      check("div1_nbytes", nbytes_b, 1);
      check("div1_sck_rises", rises_b, 40);
      check("div1_sck_period", bad_period_b, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
